rv_load_store_unit: RTL
=======================

Name: rv_load_store_unit

Overview:
- Parametrised memory-stage successor for the RV32I datapath: takes one load/store request per transaction, drives a word-aligned data-memory bus with byte enables, and returns sign/zero-extended load data.
- Adds what the current memory stage lacks: byte-lane steering, misalignment and illegal-funct3 detection, a wait-state tolerant req/ack bus, a bus timeout, and optional RV64 widths.
- Sits between execute (address from ALU, store data from RS2) and the write-back mux.

Parameters:
- XLEN, 32, data width; legal values 32 or 64. Sets the bus width and the legal funct3 set.
- ADDR_W, 32, byte address width.
- TIMEOUT, 16, number of mem_req cycles without mem_ack before the access is aborted; must be ≥1.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset; asynchronous assert, active-low.
- req_valid  in  1  request present.
- req_ready  out  1  unit can accept a request (IDLE only).
- req_store  in  1  1 = store, 0 = load.
- req_funct3  in  3  RISC-V funct3 of the load/store.
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  XLEN  store data, right-justified.
- resp_valid  out  1  one-cycle completion pulse.
- resp_rdata  out  XLEN  extended load data; 0 for stores and errors.
- resp_err  out  1  transaction failed.
- resp_err_code  out  2  0 = none, 1 = misaligned, 2 = illegal funct3, 3 = timeout.
- mem_req  out  1  bus request; held until ack or timeout.
- mem_we  out  1  write strobe.
- mem_addr  out  ADDR_W  address aligned to XLEN/8 bytes (low bits zero).
- mem_be  out  XLEN/8  byte enables.
- mem_wdata  out  XLEN  lane-steered store data.
- mem_ack  in  1  bus completion; mem_rdata is valid in the same cycle.
- mem_rdata  in  XLEN  full-word read data.

Behaviour:
- Reset (rst=0, async): state IDLE; every output 0 except req_ready=1; the timeout counter is cleared.
- States: IDLE, ACCESS, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid: capture all req_* fields and compute offset = addr mod (XLEN/8).
  - If the request is illegal or misaligned: go to RESP with an error. No mem_req is issued.
  - Otherwise: go to ACCESS. mem_req, mem_we, mem_addr, mem_be and mem_wdata are registered and valid from the next cycle.
- Legal funct3 values:
  - Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
  - Stores: 000 SB, 001 SH, 010 SW.
  - XLEN=64 adds 011 LD/SD and 110 LWU.
  - Any other value gives error code 2. Illegal funct3 takes priority over misalignment.
- Misaligned (error code 1): access size is 2/4/8 bytes and offset is not a multiple of the size.
- Store steering:
  - mem_wdata = req_wdata[size*8-1:0] shifted left by 8*offset; unused lanes are 0.
  - mem_be has `size` consecutive ones starting at bit `offset`.
- Loads drive the same mem_be pattern with mem_we=0.
- ACCESS:
  - mem_req is held high and all mem_* outputs are stable until mem_ack.
  - On mem_ack: drop mem_req (next cycle) and go to RESP.
  - For a load, extract lane bytes from mem_rdata at offset, then sign-extend (LB/LH/LW on XLEN=64) or zero-extend (LBU/LHU/LWU) to XLEN. Register the result.
  - The counter increments each ACCESS cycle without ack. When it reaches TIMEOUT: drop mem_req, go to RESP with error code 3.
  - An ack arriving in the same cycle the count hits TIMEOUT counts as success.
- RESP:
  - resp_valid=1 for exactly one cycle with rdata/err/err_code; then return to IDLE.
  - The response is not back-pressured.
  - Outside RESP, resp_valid=0 and resp_rdata/resp_err/resp_err_code hold 0.
- mem_ack outside ACCESS is ignored.
- req_valid outside IDLE is ignored; the requester must hold it until it sees req_ready.
- Latency:
  - Accept at cycle 0; mem_req high at cycle 1.
  - Ack at cycle k≥1 gives resp_valid at k+1. Zero-wait memory completes at cycle 2.
  - Error-at-accept gives resp_valid at cycle 1.
  - Throughput is at most one transaction per 3 cycles.
- Reset mid-ACCESS: mem_req drops immediately (async). No response is issued and the transaction is lost.

Test Plan:
- LB sign-extend: XLEN=32, load funct3=000, addr=0x1003, mem_rdata=0x80FF1234 ack at first mem_req cycle → mem_addr=0x1000, mem_be=4'b1000, resp at cycle 2, resp_rdata=0xFFFFFF80, err=0.
- LHU and SH lanes: LHU addr=0x2002, rdata=0xBEEF0000 → rdata=0x0000BEEF. SH addr=0x2002, wdata=0x12345678 → mem_be=4'b1100, mem_wdata=0x56780000, mem_we=1.
- Misaligned/illegal: LW addr=0x3001 → resp_valid at cycle 1, err=1, code=1, mem_req never high. funct3=011 with XLEN=32 → code=2. Store funct3=100 → code=2.
- Wait states and timeout: TIMEOUT=16, ack after 5 cycles → resp at cycle 6 with mem_* stable throughout. No ack → mem_req high exactly 16 cycles, then resp err code 3. A late ack afterwards is ignored.
- RV64 mode: XLEN=64, LWU addr=0x4004, rdata=0xF0000001_00000000 → rdata=0x00000000F0000001. LD addr=0x4004 → code 1.
- Async reset during ACCESS: rst low mid-wait → mem_req=0 and req_ready=1 without a clock edge; no resp_valid after release. A new request after release completes normally.

Source files
------------

// File: rtl/rv_load_store_unit_if.sv
// Request, response and data-memory bus bundle for the load/store unit.
interface rv_load_store_unit_if #(
    parameter int XLEN   = 32,
    parameter int ADDR_W = 32
);
    logic                req_valid;
    logic                req_ready;
    logic                req_store;
    logic [2:0]          req_funct3;
    logic [ADDR_W-1:0]   req_addr;
    logic [XLEN-1:0]     req_wdata;
    logic                resp_valid;
    logic [XLEN-1:0]     resp_rdata;
    logic                resp_err;
    logic [1:0]          resp_err_code;
    logic                mem_req;
    logic                mem_we;
    logic [ADDR_W-1:0]   mem_addr;
    logic [XLEN/8-1:0]   mem_be;
    logic [XLEN-1:0]     mem_wdata;
    logic                mem_ack;
    logic [XLEN-1:0]     mem_rdata;

    // Load/store unit side.
    modport slave (
        input  req_valid, req_store, req_funct3, req_addr, req_wdata, mem_ack, mem_rdata,
        output req_ready, resp_valid, resp_rdata, resp_err, resp_err_code,
        output mem_req, mem_we, mem_addr, mem_be, mem_wdata
    );

    // Requester / memory side.
    modport master (
        output req_valid, req_store, req_funct3, req_addr, req_wdata, mem_ack, mem_rdata,
        input  req_ready, resp_valid, resp_rdata, resp_err, resp_err_code,
        input  mem_req, mem_we, mem_addr, mem_be, mem_wdata
    );
endinterface

// File: rtl/rv_load_store_unit.sv
// RV32I/RV64I load/store unit: byte-lane steering, alignment and funct3
// checks, wait-state tolerant req/ack bus with timeout, extended load data.
module rv_load_store_unit #(
    parameter int XLEN    = 32,
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 16
) (
    input logic                 clk,
    input logic                 rst,
    rv_load_store_unit_if.slave bus
);
    localparam int NB    = XLEN / 8;
    localparam int OFF_W = $clog2(NB);
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [XLEN-1:0] ONES    = '1;
    localparam logic [NB-1:0]   BE_ONES = '1;

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
    state_t state, state_nxt;

    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [NB-1:0]     be_q;
    logic [XLEN-1:0]   wdata_q;
    logic [2:0]        f3_q;
    logic [OFF_W-1:0]  off_q;
    logic [XLEN-1:0]   rdata_q;
    logic [1:0]        code_q;
    logic [CNT_W-1:0]  cnt;

    logic [OFF_W-1:0]  off;
    int unsigned       size;
    logic              legal, misal, dec_err;
    logic [NB-1:0]     be_nxt;
    logic [XLEN-1:0]   wdata_nxt;
    logic              tmo;

    // Decode the incoming request: legality, alignment, lane steering.
    always_comb begin
        off  = bus.req_addr[OFF_W-1:0];
        size = 32'd1 << bus.req_funct3[1:0];
        case (bus.req_funct3)
            3'b000, 3'b001, 3'b010: legal = 1'b1;
            3'b011:                 legal = (XLEN == 64);
            3'b100, 3'b101:         legal = !bus.req_store;
            3'b110:                 legal = !bus.req_store && (XLEN == 64);
            default:                legal = 1'b0;
        endcase
        misal     = (32'(off) & (size - 32'd1)) != 32'd0;
        dec_err   = !legal || misal;
        // Oversized (illegal) accesses shift everything out; they never reach the bus.
        be_nxt    = (BE_ONES >> (NB - size)) << off;
        wdata_nxt = (bus.req_wdata & (ONES >> (XLEN - 8 * size))) << (8 * off);
    end

    int unsigned     lsize;
    logic [XLEN-1:0] sh, lmask, ext;

    // Pull the addressed lanes out of the bus word and sign/zero-extend.
    always_comb begin
        lsize = 32'd1 << f3_q[1:0];
        sh    = bus.mem_rdata >> (8 * off_q);
        lmask = ONES >> (XLEN - 8 * lsize);
        ext   = sh & lmask;
        // funct3[2] clear means a signed load; full-width loads have an empty ~lmask.
        if (!f3_q[2] && sh[8 * lsize - 1])
            ext = ext | ~lmask;
    end

    assign tmo = (cnt == CNT_W'(TIMEOUT - 1));

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.req_valid) state_nxt = dec_err ? RESP : ACCESS;
            ACCESS:  if (bus.mem_ack || tmo) state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Capture the request at accept, then load data / timeout status during the access.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            we_q    <= 1'b0;
            addr_q  <= '0;
            be_q    <= '0;
            wdata_q <= '0;
            f3_q    <= '0;
            off_q   <= '0;
            rdata_q <= '0;
            code_q  <= '0;
            cnt     <= '0;
        end else begin
            case (state)
                IDLE: if (bus.req_valid) begin
                    we_q    <= bus.req_store;
                    addr_q  <= {bus.req_addr[ADDR_W-1:OFF_W], OFF_W'(0)};
                    be_q    <= be_nxt;
                    wdata_q <= wdata_nxt;
                    f3_q    <= bus.req_funct3;
                    off_q   <= off;
                    rdata_q <= '0;
                    code_q  <= !legal ? 2'd2 : (misal ? 2'd1 : 2'd0);
                    cnt     <= '0;
                end
                ACCESS: begin
                    // An ack in the timeout cycle still wins.
                    if (bus.mem_ack) begin
                        rdata_q <= we_q ? '0 : ext;
                    end else begin
                        cnt <= cnt + 1'b1;
                        if (tmo) code_q <= 2'd3;
                    end
                end
                default: ;
            endcase
        end
    end

    // Outputs are gated by state so an async reset drops mem_req at once.
    always_comb begin
        bus.req_ready     = (state == IDLE);
        bus.mem_req       = (state == ACCESS);
        bus.mem_we        = (state == ACCESS) && we_q;
        bus.mem_addr      = (state == ACCESS) ? addr_q  : '0;
        bus.mem_be        = (state == ACCESS) ? be_q    : '0;
        bus.mem_wdata     = (state == ACCESS) ? wdata_q : '0;
        bus.resp_valid    = (state == RESP);
        bus.resp_rdata    = (state == RESP) ? rdata_q : '0;
        bus.resp_err      = (state == RESP) && (code_q != 2'd0);
        bus.resp_err_code = (state == RESP) ? code_q : 2'd0;
    end
endmodule
